// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: mode encodings and slice-geometry helpers shared by the
// pipelined adder and its slice.
package pipe_adder_pkg;

    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

    // Slice width handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal geometry: 1 <= stages <= width and equal-width slices.
    function automatic bit geometry_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// FullAdder: one-bit full adder cell carried over from the original
// single-cycle ripple-carry adder.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: combinational CHUNK-bit ripple adder built from FullAdder
// cells. Also exposes the carry into its top bit (for signed overflow when this
// is the most significant slice) and a slice-is-zero term.
module pipe_adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_top,
    output logic             zero
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
        FullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_top = c[CHUNK-1];
    assign zero  = ~|sum;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES slices, one slice per
// pipeline stage, with a single global stall (advance) for backpressure.
// Define PIPE_ADDER_SAT_EN to saturate the result to the signed limit on
// overflow; without it the sum wraps modulo 2^WIDTH.
//
// Each stage carries a rotating word: the low slice is consumed as operand A
// and its sum is inserted at the top, so after STAGES rotations the word holds
// the finished sum in place. Operand B shrinks by one slice per stage.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Last-stage combinational results, feeding the output registers.
    logic [WIDTH-1:0] last_r;
    logic             last_co, last_ct, last_z, last_v;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             out_valid_d, out_valid_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

    // Global stall and effective operands for the first slice.
    always_comb begin
        advance  = !out_valid_q || out_ready;
        in_ready = rst_n && advance;
        b_eff    = (sub == SUB_MODE) ? ~b : b;
        c0       = (sub == ADD_MODE) ? cin : 1'b1;
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stg
        localparam int BW = WIDTH - k * CHUNK;

        logic [WIDTH-1:0] r_in, r_nxt;
        logic [BW-1:0]    b_in;
        logic             c_in, z_in, v_in;
        logic [CHUNK-1:0] s;
        logic             co, sz;

        if (k == 0) begin : g_src
            assign r_in = a;
            assign b_in = b_eff;
            assign c_in = c0;
            assign z_in = 1'b1;
            assign v_in = in_valid && in_ready;
        end else begin : g_src
            assign r_in = gen_stg[k-1].g_reg.r_q;
            assign b_in = gen_stg[k-1].g_reg.b_q;
            assign c_in = gen_stg[k-1].g_reg.c_q;
            assign z_in = gen_stg[k-1].g_reg.z_q;
            assign v_in = gen_stg[k-1].g_reg.v_q;
        end

        // Only the most significant slice needs its top-bit carry.
        if (k == STAGES - 1) begin : g_last
            logic ct;
            pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
                .a     (r_in[CHUNK-1:0]),
                .b     (b_in[CHUNK-1:0]),
                .cin   (c_in),
                .sum   (s),
                .cout  (co),
                .c_top (ct),
                .zero  (sz)
            );
            assign last_r  = r_nxt;
            assign last_co = co;
            assign last_ct = ct;
            assign last_z  = z_in & sz;
            assign last_v  = v_in;
        end else begin : g_mid
            pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
                .a     (r_in[CHUNK-1:0]),
                .b     (b_in[CHUNK-1:0]),
                .cin   (c_in),
                .sum   (s),
                .cout  (co),
                .c_top (),
                .zero  (sz)
            );
        end

        assign r_nxt = WIDTH'({s, r_in} >> CHUNK);

        if (k < STAGES - 1) begin : g_reg
            localparam int BWN = BW - CHUNK;

            logic [WIDTH-1:0] r_d, r_q;
            logic [BWN-1:0]   b_d, b_q;
            logic             c_d, c_q, z_d, z_q, v_d, v_q;

            // Stage k next state: shift in on advance, otherwise hold.
            always_comb begin
                r_d = r_q;
                b_d = b_q;
                c_d = c_q;
                z_d = z_q;
                v_d = v_q;
                if (advance) begin
                    r_d = r_nxt;
                    b_d = BWN'(b_in >> CHUNK);
                    c_d = co;
                    z_d = z_in & sz;
                    v_d = v_in;
                end
            end

            // Stage k registers; reset drops any in-flight op.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    z_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    r_q <= r_d;
                    b_q <= b_d;
                    c_q <= c_d;
                    z_q <= z_d;
                    v_q <= v_d;
                end
            end
        end
    end

    // Output stage: final slice result, flags and optional saturation.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            sum_d       = last_r;
            cout_d      = last_co;
            ovf_d       = last_ct ^ last_co;
            zero_d      = last_z;
            out_valid_d = last_v;
`ifdef PIPE_ADDER_SAT_EN
            // Result sign 1 after overflow means the true value was positive.
            if (ovf_d) begin
                sum_d  = last_r[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
                zero_d = 1'b0;
            end
`endif
        end
    end

    // Output registers drive the ports directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: random and directed checks of pipe_adder against a signed /
// unsigned arithmetic reference model. Main DUT is 32 bits / 4 stages; a
// WIDTH=8 sweep instantiates STAGES = 1, 2, 4, 8.
module tb_pipe_adder;

    localparam int W       = 32;
    localparam int S       = 4;
    localparam int SWEEP_N = 1000;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic         cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    logic            sw_in_valid, sw_cin, sw_sub, sw_out_ready;
    logic [7:0]      sw_a, sw_b;
    logic [3:0]      sw_in_ready, sw_out_valid, sw_cout, sw_ovf, sw_zero;
    logic [3:0][7:0] sw_sum;

    int n_checks = 0;
    int n_errors = 0;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    for (genvar j = 0; j < 4; j++) begin : g_sw
        pipe_adder #(.WIDTH(8), .STAGES(1 << j)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[j]),
            .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_out_valid[j]),
            .out_ready(sw_out_ready), .sum(sw_sum[j]), .cout(sw_cout[j]),
            .ovf(sw_ovf[j]), .zero(sw_zero[j])
        );
    end

    // Reference: true unsigned and signed results, then wrap / saturate.
    function automatic void model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [31:0] s, output logic co,
                                  output logic ov, output logic z);
        longint m, half, ua, ub, sa, sb, ures, sres;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(ma) & (m - 1);
        ub   = longint'(mb) & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (msub) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(mcin);
            sres = sa + sb + longint'(mcin);
            co   = (ures >= m);
        end
        ov = (sres >= half) || (sres < -half);
        s  = 32'(ures & (m - 1));
`ifdef PIPE_ADDER_SAT_EN
        if (ov) s = (sres > 0) ? 32'(half - 1) : 32'(half);
`endif
        z = (s == 32'd0);
    endfunction

    // Pipeline drain with the consumer always ready.
    task automatic idle(input int n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    // Present one op, then wait (bounded) for its result.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tcin,
                          input logic tsub, output logic [31:0] rs, output logic rc,
                          output logic ro, output logic rz, output int lat);
        @(negedge clk);
        a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; ro = ovf; rz = zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (sum !== '0) begin n_errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
        n_checks++; if (sw_out_valid !== 4'h0) begin n_errors++; $display("FAIL reset_sweep_valid: got %b want 0000", sw_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] da[8] = '{32'hFFFFFFFF, 32'd5, 32'd7, 32'h7FFFFFFF,
                               32'h80000000, 32'h12345678, 32'd0, 32'h80000000};
        logic [31:0] db[8] = '{32'd1, 32'd7, 32'd5, 32'd1,
                               32'd1, 32'd0, 32'd0, 32'h80000000};
        logic dc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ds[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] es, rs;
        logic ec, eo, ez, rc, ro, rz;
        int lat;
        for (int i = 0; i < 8; i++) begin
            model(W, da[i], db[i], dc[i], ds[i], es, ec, eo, ez);
            run_op(da[i], db[i], dc[i], ds[i], rs, rc, ro, rz, lat);
            n_checks++; if (lat != S) begin n_errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, S); end
            n_checks++; if (rs !== es) begin n_errors++; $display("FAIL dir%0d_sum: got %h want %h", i, rs, es); end
            n_checks++; if ({rc, ro, rz} !== {ec, eo, ez}) begin n_errors++; $display("FAIL dir%0d_flags(c,o,z): got %b want %b", i, {rc, ro, rz}, {ec, eo, ez}); end
            if (i == 0) begin
                n_checks++; if ({rs, rc, ro, rz} !== {32'd0, 3'b101}) begin n_errors++; $display("FAIL plan_wrap: got %h/%b want 0/101", rs, {rc, ro, rz}); end
            end
            if (i == 3) begin
`ifdef PIPE_ADDER_SAT_EN
                n_checks++; if ({rs, ro, rz} !== {32'h7FFFFFFF, 2'b10}) begin n_errors++; $display("FAIL plan_ovf: got %h/%b want 7fffffff/10", rs, {ro, rz}); end
`else
                n_checks++; if ({rs, ro} !== {32'h80000000, 1'b1}) begin n_errors++; $display("FAIL plan_ovf: got %h/%b want 80000000/1", rs, ro); end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t e, held;
        logic [31:0] na, nb;
        logic ncin, nsub, stall_prev;
        int sent, got, cyc;
        idle(6);
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0;
        held = '{s: 32'd0, c: 1'b0, o: 1'b0, z: 1'b0};
        na = $urandom; nb = $urandom; ncin = 1'($urandom); nsub = 1'($urandom);
        while ((sent < 16 || got < 16) && cyc < 400) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 16);
            a = na; b = nb; cin = ncin; sub = nsub;
            #1;
            n_checks++; if (in_ready !== !(out_valid && !out_ready)) begin n_errors++; $display("FAIL b2b_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready)); end
            if (stall_prev) begin
                n_checks++; if ({out_valid, sum, cout, ovf, zero} !== {1'b1, held.s, held.c, held.o, held.z}) begin
                    n_errors++; $display("FAIL b2b_stall_stable: got %b/%h want 1/%h", out_valid, sum, held.s);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = '{s: sum, c: cout, o: ovf, z: zero};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL b2b_extra_result: got %h want none", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf, zero} !== {e.s, e.c, e.o, e.z}) begin
                        n_errors++; $display("FAIL b2b_result%0d: got %h/%b want %h/%b", got, sum, {cout, ovf, zero}, e.s, {e.c, e.o, e.z});
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                model(W, na, nb, ncin, nsub, e.s, e.c, e.o, e.z);
                exp_q.push_back(e);
                sent++;
                na = $urandom; nb = $urandom; ncin = 1'($urandom); nsub = 1'($urandom);
            end
            @(posedge clk);
            cyc++;
        end
        n_checks++; if (got != 16 || sent != 16 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL b2b_count: got %0d sent %0d left %0d want 16/16/0", got, sent, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] es, rs;
        logic ec, eo, ez, rc, ro, rz;
        int lat;
        idle(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({out_valid, sum} !== {1'b0, 32'd0}) begin n_errors++; $display("FAIL rst_mid_clear: got %b/%h want 0/0", out_valid, sum); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stale%0d: got %b want 0", i, out_valid); end
        end
        model(W, 32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, es, ec, eo, ez);
        run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, rs, rc, ro, rz, lat);
        n_checks++; if (lat != S) begin n_errors++; $display("FAIL rst_mid_latency: got %0d want %0d", lat, S); end
        n_checks++; if ({rs, rc, ro, rz} !== {es, ec, eo, ez}) begin n_errors++; $display("FAIL rst_mid_result: got %h/%b want %h/%b", rs, {rc, ro, rz}, es, {ec, eo, ez}); end
    endtask

    task automatic test_sweep();
        logic [7:0] ta[SWEEP_N];
        logic [7:0] tbv[SWEEP_N];
        logic       tc[SWEEP_N];
        logic       ts[SWEEP_N];
        logic       tv[SWEEP_N];
        logic [31:0] es;
        logic ec, eo, ez, ev;
        int idx;
        sw_out_ready = 1'b1;
        for (int i = 0; i < SWEEP_N + 10; i++) begin
            @(negedge clk);
            if (i < SWEEP_N) begin
                ta[i] = 8'($urandom); tbv[i] = 8'($urandom);
                tc[i] = 1'($urandom); ts[i] = 1'($urandom);
                tv[i] = ($urandom_range(0, 7) != 0);
                sw_a = ta[i]; sw_b = tbv[i]; sw_cin = tc[i]; sw_sub = ts[i]; sw_in_valid = tv[i];
            end else begin
                sw_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++; if (sw_in_ready !== 4'hF) begin n_errors++; $display("FAIL sweep_in_ready: got %b want 1111", sw_in_ready); end
            for (int j = 0; j < 4; j++) begin
                idx = i - (1 << j) + 1;
                ev  = (idx >= 0 && idx < SWEEP_N) ? tv[idx] : 1'b0;
                n_checks++; if (sw_out_valid[j] !== ev) begin n_errors++; $display("FAIL sweep_s%0d_valid@%0d: got %b want %b", 1 << j, i, sw_out_valid[j], ev); end
                if (ev) begin
                    model(8, {24'd0, ta[idx]}, {24'd0, tbv[idx]}, tc[idx], ts[idx], es, ec, eo, ez);
                    n_checks++; if ({sw_sum[j], sw_cout[j], sw_ovf[j], sw_zero[j]} !== {es[7:0], ec, eo, ez}) begin
                        n_errors++; $display("FAIL sweep_s%0d_op%0d: got %h/%b want %h/%b", 1 << j, idx, sw_sum[j], {sw_cout[j], sw_ovf[j], sw_zero[j]}, es[7:0], {ec, eo, ez});
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
